// File: rtl/vote_winner_scan.sv
// Sequential winner finder over NUM_CAND packed vote counters: snapshot on start,
// one candidate per clock, reports 1-based winner, its count, tie and no-vote flags.
module vote_winner_scan #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = $clog2(NUM_CAND + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_CAND*CNT_W-1:0] vote_counts,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W-1:0]          winner,
  output logic [CNT_W-1:0]          winning_votes,
  output logic                      tie,
  output logic                      no_votes
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CAND);

  state_t                      state_q, state_d;
  logic [NUM_CAND*CNT_W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            cur_q, cur_d;
  logic [CNT_W-1:0]            max_q, max_d;
  logic [IDX_W-1:0]            max_idx_q, max_idx_d;
  logic                        run_tie_q, run_tie_d;
  logic                        done_q, done_d;
  logic [IDX_W-1:0]            winner_q, winner_d;
  logic [CNT_W-1:0]            votes_q, votes_d;
  logic                        tie_q, tie_d;
  logic                        no_votes_q, no_votes_d;

  // The snapshot shifts down one candidate per cycle into cur_q; the compare
  // runs one cycle behind the fetch, so cur_q holds candidate idx_q (1-based).
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    cur_d      = cur_q;
    max_d      = max_q;
    max_idx_d  = max_idx_q;
    run_tie_d  = run_tie_q;
    done_d     = 1'b0;
    winner_d   = winner_q;
    votes_d    = votes_q;
    tie_d      = tie_q;
    no_votes_d = no_votes_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          snap_d    = vote_counts;
          idx_d     = '0;
          cur_d     = '0;
          max_d     = '0;
          max_idx_d = '0;
          run_tie_d = 1'b0;
        end
      end
      SCAN: begin
        cur_d  = snap_q[CNT_W-1:0];
        snap_d = snap_q >> CNT_W;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q != '0) begin
          // Strict > keeps the lowest index on ties; zero counts never win or tie.
          if (cur_q > max_q) begin
            max_d     = cur_q;
            max_idx_d = idx_q;
            run_tie_d = 1'b0;
          end else if (cur_q == max_q && max_q != '0) begin
            run_tie_d = 1'b1;
          end
        end
        if (idx_q == LAST) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          winner_d   = max_idx_d;
          votes_d    = max_d;
          tie_d      = run_tie_d;
          no_votes_d = (max_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      idx_q      <= '0;
      cur_q      <= '0;
      max_q      <= '0;
      max_idx_q  <= '0;
      run_tie_q  <= 1'b0;
      done_q     <= 1'b0;
      winner_q   <= '0;
      votes_q    <= '0;
      tie_q      <= 1'b0;
      no_votes_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      run_tie_q  <= run_tie_d;
      done_q     <= done_d;
      winner_q   <= winner_d;
      votes_q    <= votes_d;
      tie_q      <= tie_d;
      no_votes_q <= no_votes_d;
    end
  end

  assign busy          = (state_q == SCAN);
  assign done          = done_q;
  assign winner        = winner_q;
  assign winning_votes = votes_q;
  assign tie           = tie_q;
  assign no_votes      = no_votes_q;

endmodule
